hls_skid_register: RTL

HLS_SKID_REGISTER -- requirements
Module: hls_skid_register

---
 rtl/hls_skid_register.sv | 85 ++++++++
 1 files changed

// File: rtl/hls_skid_register.sv
// Two-entry skid buffer for a valid/ready pipeline stage. out_data comes straight from
// the main register. in_ready depends only on registered state, flush and reset.
module hls_skid_register #(
  parameter int unsigned      width      = 32,
  parameter logic [width-1:0] init_value = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [width-1:0] main_q, main_d;
  logic [width-1:0] skid_q, skid_d;
  logic             in_xfer;
  logic             out_xfer;

  // Gating with reset keeps both handshakes low for the whole time reset is asserted.
  assign in_ready  = reset & ~flush & (state_q != ST_FULL);
  assign out_valid = reset & ~flush & (state_q != ST_EMPTY);
  assign out_data  = main_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A flush already masks both handshakes, so the data registers keep their contents.
    if (flush) state_d = ST_EMPTY;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= init_value;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
